// File: rtl/uart_host_controller.sv
// Host-side UART command initiator: serializes AA/BB/CC/DD command frames onto
// the system's serial input and collects up to two response frames into one word.
module uart_host_controller #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned PRESCALE         = 8,
  parameter int unsigned INTER_FRAME_GAP  = 3,
  parameter int unsigned PARITY_TYPE      = 0,
  parameter int unsigned RESPONSE_TIMEOUT = 4096
) (
  input  logic                      UART_clk,
  input  logic                      reset,
  input  logic                      command_valid,
  output logic                      command_ready,
  input  logic [1:0]                command_type,
  input  logic [DATA_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [DATA_WIDTH-1:0]     alu_function,
  output logic                      serial_data_out,
  input  logic                      serial_data_in,
  output logic                      response_valid,
  output logic [2*DATA_WIDTH-1:0]   response_data,
  output logic                      parity_error,
  output logic                      frame_error,
  output logic                      timeout_error
);

  localparam int unsigned FRAME_BITS = DATA_WIDTH + 3;
  localparam int unsigned LAST_BIT   = FRAME_BITS - 1;
  localparam int unsigned PAR_BIT    = DATA_WIDTH + 1;
  localparam int unsigned BW         = $clog2(FRAME_BITS);
  localparam int unsigned CMAX       = (PRESCALE > INTER_FRAME_GAP) ? PRESCALE : INTER_FRAME_GAP;
  localparam int unsigned CW         = $clog2(CMAX);
  localparam int unsigned TW         = $clog2(RESPONSE_TIMEOUT + 1);
  localparam int unsigned RW         = 2 * DATA_WIDTH;
  localparam logic        PAR_ODD    = (PARITY_TYPE != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_BIT, S_TX_GAP, S_RX_WAIT, S_RX_BIT, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [BW-1:0]         r_bit, w_bit_nxt, w_bit_inc;
  logic [TW-1:0]         r_tmo, w_tmo_nxt;
  logic [DATA_WIDTH-1:0] r_tx_bytes [4];
  logic [DATA_WIDTH-1:0] w_tx_bytes_nxt [4];
  logic [1:0]            r_tx_idx, w_tx_idx_nxt, r_tx_last, w_tx_last_nxt;
  logic [1:0]            r_rx_total, w_rx_total_nxt, r_rx_idx, w_rx_idx_nxt;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic                  r_sdo, w_sdo_nxt, r_ready, w_ready_nxt, r_rv, w_rv_nxt;
  logic [RW-1:0]         r_rdata, w_rdata_nxt;
  logic                  r_perr, w_perr_nxt, r_ferr, w_ferr_nxt, r_terr, w_terr_nxt;
  logic [DATA_WIDTH-1:0] w_tx_byte;
  logic [FRAME_BITS-1:0] w_tx_frame;
  logic                  w_rx_par_exp;

  // Frame currently on the line: stop, parity, data (LSB first), start.
  assign w_tx_byte    = r_tx_bytes[r_tx_idx];
  assign w_tx_frame   = {1'b1, (^w_tx_byte) ^ PAR_ODD, w_tx_byte, 1'b0};
  assign w_bit_inc    = r_bit + BW'(1);
  assign w_rx_par_exp = (^r_rx_shift) ^ PAR_ODD;

  always_ff @(posedge UART_clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_tmo_nxt      = r_tmo;
    w_tx_bytes_nxt = r_tx_bytes;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_last_nxt  = r_tx_last;
    w_rx_total_nxt = r_rx_total;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_sdo_nxt      = r_sdo;
    w_rdata_nxt    = r_rdata;
    w_perr_nxt     = r_perr;
    w_ferr_nxt     = r_ferr;
    w_terr_nxt     = r_terr;
    case (r_state)
      S_IDLE: begin
        if (command_valid && r_ready) begin
          w_state_nxt       = S_TX_BIT;
          w_cnt_nxt         = '0;
          w_bit_nxt         = '0;
          w_tx_idx_nxt      = '0;
          w_rx_idx_nxt      = '0;
          w_sdo_nxt         = 1'b0;
          w_rdata_nxt       = '0;
          w_perr_nxt        = 1'b0;
          w_ferr_nxt        = 1'b0;
          w_terr_nxt        = 1'b0;
          w_tx_bytes_nxt[1] = address;
          w_tx_bytes_nxt[2] = write_data;
          w_tx_bytes_nxt[3] = '0;
          case (command_type)
            2'b00: begin
              w_tx_bytes_nxt[0] = DATA_WIDTH'(8'hAA);
              w_tx_last_nxt     = 2'd2;
              w_rx_total_nxt    = 2'd0;
            end
            2'b01: begin
              w_tx_bytes_nxt[0] = DATA_WIDTH'(8'hBB);
              w_tx_last_nxt     = 2'd1;
              w_rx_total_nxt    = 2'd1;
            end
            2'b10: begin
              w_tx_bytes_nxt[0] = DATA_WIDTH'(8'hCC);
              w_tx_bytes_nxt[1] = operand_a;
              w_tx_bytes_nxt[2] = operand_b;
              w_tx_bytes_nxt[3] = alu_function;
              w_tx_last_nxt     = 2'd3;
              w_rx_total_nxt    = 2'd2;
            end
            default: begin
              w_tx_bytes_nxt[0] = DATA_WIDTH'(8'hDD);
              w_tx_bytes_nxt[1] = alu_function;
              w_tx_last_nxt     = 2'd1;
              w_rx_total_nxt    = 2'd2;
            end
          endcase
        end
      end
      S_TX_BIT: begin
        if (r_cnt == CW'(PRESCALE - 1)) begin
          w_cnt_nxt = '0;
          if (r_bit == BW'(LAST_BIT)) begin
            w_state_nxt = S_TX_GAP;
            w_sdo_nxt   = 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_sdo_nxt = w_tx_frame[w_bit_inc];
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_TX_GAP: begin
        if (r_cnt == CW'(INTER_FRAME_GAP - 1)) begin
          w_cnt_nxt = '0;
          if (r_tx_idx != r_tx_last) begin
            w_state_nxt  = S_TX_BIT;
            w_tx_idx_nxt = r_tx_idx + 2'd1;
            w_bit_nxt    = '0;
            w_sdo_nxt    = 1'b0;
          end else if (r_rx_total != 2'd0) begin
            w_state_nxt = S_RX_WAIT;
            w_tmo_nxt   = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RX_WAIT: begin
        // Detection cycle counts as cycle 0 of the start bit.
        if (!serial_data_in) begin
          w_state_nxt = S_RX_BIT;
          w_cnt_nxt   = CW'(1);
          w_bit_nxt   = '0;
          w_tmo_nxt   = '0;
        end else if (r_tmo == TW'(RESPONSE_TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          w_terr_nxt  = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_RX_BIT: begin
        if (r_cnt == CW'(PRESCALE - 1)) begin
          w_cnt_nxt = '0;
          w_bit_nxt = w_bit_inc;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        if (r_cnt == CW'(PRESCALE / 2)) begin
          if (r_bit == '0) begin
            if (serial_data_in) begin
              w_state_nxt = S_RX_WAIT;
              w_tmo_nxt   = '0;
            end
          end else if (r_bit <= BW'(DATA_WIDTH)) begin
            w_rx_shift_nxt = {serial_data_in, r_rx_shift[DATA_WIDTH-1:1]};
          end else if (r_bit == BW'(PAR_BIT)) begin
            if (serial_data_in != w_rx_par_exp) w_perr_nxt = 1'b1;
          end else begin
            if (!serial_data_in) w_ferr_nxt = 1'b1;
            if (r_rx_idx == 2'd0) w_rdata_nxt[DATA_WIDTH-1:0] = r_rx_shift;
            else                  w_rdata_nxt[RW-1:DATA_WIDTH] = r_rx_shift;
            w_rx_idx_nxt = r_rx_idx + 2'd1;
            if (r_rx_idx + 2'd1 == r_rx_total) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RX_WAIT;
              w_tmo_nxt   = '0;
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_rv_nxt    = (w_state_nxt == S_DONE);
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge UART_clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tmo      <= '0;
      for (int i = 0; i < 4; i++) r_tx_bytes[i] <= '0;
      r_tx_idx   <= '0;
      r_tx_last  <= '0;
      r_rx_total <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_sdo      <= 1'b1;
      r_ready    <= 1'b1;
      r_rv       <= 1'b0;
      r_rdata    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tx_bytes <= w_tx_bytes_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_last  <= w_tx_last_nxt;
      r_rx_total <= w_rx_total_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_sdo      <= w_sdo_nxt;
      r_ready    <= w_ready_nxt;
      r_rv       <= w_rv_nxt;
      r_rdata    <= w_rdata_nxt;
      r_perr     <= w_perr_nxt;
      r_ferr     <= w_ferr_nxt;
      r_terr     <= w_terr_nxt;
    end
  end

  assign serial_data_out = r_sdo;
  assign command_ready   = r_ready;
  assign response_valid  = r_rv;
  assign response_data   = r_rdata;
  assign parity_error    = r_perr;
  assign frame_error     = r_ferr;
  assign timeout_error   = r_terr;

endmodule

// File: doc/uart_host_controller.md
# uart_host_controller

Host-side initiator for the system's UART command protocol. It serializes command sequences into 11-bit UART frames and drives the system's `serial_data_in`. Supported sequences are register write (0xAA), register read (0xBB), ALU with operands (0xCC) and ALU without operands (0xDD). It then deserializes the system's response frames from `serial_data_out` and returns them as a single response word. It sits on the `UART_clk` domain opposite the system top, in the same clock domain the UART block uses.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE, 8, `UART_clk` cycles per serial bit; even, ≥4
- INTER_FRAME_GAP, 3, idle-high cycles after each transmitted frame
- PARITY_TYPE, 0, 0 = even, 1 = odd
- RESPONSE_TIMEOUT, 4096, idle cycles allowed while waiting for each response start bit
- UART_clk  input  1  sole clock
- reset  input  1  asynchronous, active-low
- command_valid  input  1  command request
- command_ready  output  1  high only in IDLE
- command_type  input  2  00 write, 01 read, 10 ALU with operands, 11 ALU without operands
- address  input  DATA_WIDTH  register address (write/read)
- write_data  input  DATA_WIDTH  write payload
- operand_a, operand_b  input  DATA_WIDTH each  ALU operands (type 10)
- alu_function  input  DATA_WIDTH  ALU function code (types 10/11)
- serial_data_out  output  1  to system `serial_data_in`; idle high
- serial_data_in  input  1  from system `serial_data_out`
- response_valid  output  1  one-cycle completion pulse
- response_data  output  2*DATA_WIDTH  {high byte, low byte}
- parity_error, frame_error, timeout_error  output  1 each  status, valid with response_valid

## Operation
- Frame format: start (0), DATA_WIDTH bits LSB first, parity bit, stop (1). Parity bit = ^data for even parity, ~^data for odd parity.
- Frame lists per command type, all captured on accept:
  - 00: AA, address, write_data; 0 response frames
  - 01: BB, address; 1 response frame
  - 10: CC, operand_a, operand_b, alu_function; 2 response frames
  - 11: DD, alu_function; 2 response frames
- States and transitions:
  - IDLE → TX_BIT on command_valid & command_ready.
  - TX_BIT: each bit is held PRESCALE cycles. After the stop bit → TX_GAP.
  - TX_GAP: line held high for INTER_FRAME_GAP cycles. Then → TX_BIT for the next frame, RX_WAIT if responses are expected, or DONE otherwise.
  - RX_WAIT: waits for serial_data_in = 0. On detection → RX_BIT. Timeout counter reaching RESPONSE_TIMEOUT → DONE with timeout_error.
  - RX_BIT: samples at cycle PRESCALE/2 of each bit. A start bit sampled high is a glitch → RX_WAIT. After the stop sample → RX_WAIT for more frames, else DONE.
  - DONE: response_valid = 1 for exactly one cycle, then → IDLE.
- Response packing:
  - First received frame → response_data[DATA_WIDTH-1:0].
  - Second received frame → the upper byte.
  - Bytes not received read 0. Writes return 0.
- Error flags (sticky OR across frames within a command):
  - parity_error = received parity mismatch.
  - frame_error = stop sample 0.
  - timeout_error = timeout occurred.
  - Flags and response_data hold until the next command is accepted, then clear.
- serial_data_in is ignored outside RX_WAIT/RX_BIT.
- command inputs are don't-care when command_ready = 0.

## Timing
- Reset values:
  - state IDLE, command_ready = 1, serial_data_out = 1, response_valid = 0.
  - response_data = 0, all error flags = 0, all counters = 0.
- Reset asserted mid-operation: serial_data_out forced to 1 asynchronously, any frame is abandoned, no response_valid.
- Accept at edge N: serial_data_out = 0 from edge N+1, and command_ready = 0 from edge N+1.
- Frame duration: 11*PRESCALE cycles (88 at defaults). One frame plus gap = 91 cycles.
- Write latency: 3*91 = 273 cycles from first start-bit cycle to DONE. response_valid is high in cycle 274. command_ready returns the cycle after.
- Receive timing: the start bit is detected on the first cycle serial_data_in is sampled 0. The stop bit is sampled 10*PRESCALE + PRESCALE/2 cycles later.
- The DONE cycle follows the stop sample of the final expected frame by one cycle.
- The timeout counter resets on entering RX_WAIT and on each detected start.

## Test plan
- Write, address 0x05, data 0x3C: line carries frames AA (parity 0), 05 (parity 0), 3C (parity 0) at 88-cycle frames with 3-cycle gaps. response_valid at cycle 274, response_data = 0x0000, no flags.
- Read, address 0x05: frames BB, 05. A bench responder returns 0x3C → response_data = 0x003C, parity_error = frame_error = timeout_error = 0.
- ALU with operands (0x12, 0x34, function 0x00): frames CC, 12, 34, 00. Responder returns 0x46 then 0x00 → response_data = 0x0046.
- ALU without operands, function 0x02: responder returns 0x3A then 0x00 with the parity bit of the first frame inverted → parity_error = 1, response_data = 0x003A. Flag clears on the next accept.
- Read with the responder stop bit forced 0 → frame_error = 1. Read with no response → timeout_error = 1 after 4096 idle cycles, response_data = 0.
- Reset pulse during the second frame of a write → serial_data_out = 1 immediately, no response_valid, command_ready = 1. A following read completes normally.
